mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
- Parametrised successor to the two-CPU memory controller arbiter.
- Arbitrates instruction and data requests from CPUS caches onto a single RAM port.
- Uses a registered grant FSM, separate round-robin pointers for the data and instruction classes, and an anti-starvation limit for instruction fetches.
- Sits between the per-CPU caches and RAM. The coherence controller drives the data-side request inputs.

Parameters:
- CPUS, 2, number of cache pairs (≥2).
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- MAX_DATA_RUN, 4, maximum consecutive data grants while any instruction request is pending (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  CPUS  per-CPU instruction read request.
- iaddr  in  CPUS*ADDR_W  per-CPU instruction address; CPU k occupies bits [k*ADDR_W +: ADDR_W].
- dREN  in  CPUS  per-CPU data read request.
- dWEN  in  CPUS  per-CPU data write request.
- daddr  in  CPUS*ADDR_W  per-CPU data address.
- dstore  in  CPUS*DATA_W  per-CPU write data.
- iwait  out  CPUS  instruction wait, active high.
- dwait  out  CPUS  data wait, active high.
- iload  out  CPUS*DATA_W  ramload broadcast to every CPU.
- dload  out  CPUS*DATA_W  ramload broadcast to every CPU.
- ramstate  in  2  ram state: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramload  in  DATA_W  read data from RAM.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.

Behaviour:
- Reset (async, immediate on RST=1), and any reset mid-transfer:
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=all 1s, dwait=all 1s.
  - FSM=IDLE; both RR pointers=0; run counter=0.
  - An in-flight access is dropped; no completion is signalled.
- FSM has two states:
  - IDLE: RAM enables=0, all waits=1.
  - GRANT: holds the registered grant (class, index).
- IDLE → GRANT when any request is pending; the grant is latched at the clock edge. RAM enables assert the following cycle, so there is a minimum 1-cycle grant latency.
- Class selection:
  - Data class (dREN|dWEN) wins over instruction class,
  - unless run counter == MAX_DATA_RUN and any iREN is set; then instruction wins.
- Index selection within a class: round robin, searching from that class's pointer upward with modulo-CPUS wrap.
- RAM drive in GRANT:
  - Data, dWEN=1: ramWEN=1, ramREN=0, ramaddr=daddr[g], ramstore=dstore[g].
  - Data with dWEN=1 and dREN=1 is treated as a write.
  - Data, dREN only: ramREN=1.
  - Instruction: ramREN=1, ramaddr=iaddr[g], ramstore=0.
- Completion: in GRANT with ramstate==ACCESS, the granted wait (dwait[g] or iwait[g]) = 0 combinationally for exactly that cycle. On that edge:
  - FSM → IDLE;
  - the class pointer ← (g+1) mod CPUS;
  - run counter: +1 (saturating at MAX_DATA_RUN) on a data completion; cleared on an instruction completion, or on a data completion when no iREN is pending.
- All non-granted waits stay 1 at all times.
- Back-to-back: a new grant can be latched on the edge after completion, giving one IDLE cycle between RAM accesses.
- Abort: the granted request deasserts while in GRANT → IDLE next edge; no wait pulse, pointers and counter unchanged.
- ERROR or BUSY: hold the grant and all RAM outputs unchanged (retry) until ACCESS or abort.
- Requests arriving during GRANT do not preempt the current grant.
- iload/dload are combinational copies of ramload for all CPUs; consumers sample them on wait=0.

Test Plan (CPUS=2, MAX_DATA_RUN=4):
- Single fetch:
  - Stimulus: iREN[1]=1, iaddr[1]=0x40, RAM returns ACCESS 2 cycles after ramREN.
  - Required: ramREN=1 and ramaddr=0x40 from cycle 1; iwait[1]=0 for one cycle; iwait[0], dwait stay 1.
- Data round robin:
  - Stimulus: dREN[0]=1 and dREN[1]=1 held continuously.
  - Required: grants alternate 0,1,0,1; a third simultaneous request after a CPU1 completion grants CPU0.
- Write priority and starvation:
  - Stimulus: dWEN[0]=1 with dstore=0xDEADBEEF, iREN[1]=1, both held.
  - Required: 4 writes with ramWEN=1 and ramstore=0xDEADBEEF; the 5th grant is the instruction; then writes resume.
- Abort:
  - Stimulus: dREN[1] granted, dropped before ACCESS.
  - Required: FSM returns to IDLE; dwait[1] never 0; data pointer still 1.
- ERROR retry:
  - Stimulus: ramstate = ERROR for 3 cycles, then ACCESS.
  - Required: ramaddr/ramREN stable for all 3 cycles; a single wait pulse on ACCESS.
- Async reset mid-GRANT:
  - Stimulus: RST pulsed between clock edges.
  - Required: ramREN, ramWEN go 0 and waits go all 1 immediately; after release, the next request is granted to index 0.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter for per-CPU instruction/data cache requests onto one RAM port.
// The grant is registered; data outranks instruction fetches except when a fetch has starved.
module mem_arbiter_rr #(
    parameter int unsigned CPUS         = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic [CPUS*DATA_W-1:0]   dload,
    input  logic [1:0]               ramstate,
    input  logic [DATA_W-1:0]        ramload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore
);

    localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [1:0] RamAccess = 2'd2;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic            cls_q, cls_d;        // 1: data class, 0: instruction class
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   dptr_q, dptr_d;
    logic [IW-1:0]   iptr_q, iptr_d;
    logic [RW-1:0]   run_q, run_d;

    logic [CPUS-1:0] dreq;
    logic            g_live;
    logic [IW-1:0]   gidx_nxt;

    assign dreq     = dREN | dWEN;
    assign g_live   = cls_q ? dreq[gidx_q] : iREN[gidx_q];
    assign gidx_nxt = (gidx_q == IW'(CPUS - 1)) ? '0 : gidx_q + 1'b1;
    assign iload    = {CPUS{ramload}};
    assign dload    = {CPUS{ramload}};

    // First requester at or above ptr, wrapping modulo CPUS.
    function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned off = 0; off < CPUS; off++) begin
            idx = (32'(ptr) + off) % CPUS;
            if (!found && req[IW'(idx)]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        gidx_d   = gidx_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        run_d    = run_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        unique case (state_q)
            StIdle: begin
                if ((|dreq) || (|iREN)) begin
                    state_d = StGrant;
                    if ((|iREN) && (!(|dreq) || run_q == RW'(MAX_DATA_RUN))) begin
                        cls_d  = 1'b0;
                        gidx_d = rr_pick(iREN, iptr_q);
                    end else begin
                        cls_d  = 1'b1;
                        gidx_d = rr_pick(dreq, dptr_q);
                    end
                end
            end
            StGrant: begin
                if (!g_live) begin
                    // Abort: requester withdrew, leave pointers and run count alone.
                    state_d = StIdle;
                end else begin
                    if (cls_q) begin
                        ramWEN   = dWEN[gidx_q];
                        ramREN   = !dWEN[gidx_q];
                        ramaddr  = daddr[32'(gidx_q)*ADDR_W +: ADDR_W];
                        ramstore = dstore[32'(gidx_q)*DATA_W +: DATA_W];
                    end else begin
                        ramREN   = 1'b1;
                        ramaddr  = iaddr[32'(gidx_q)*ADDR_W +: ADDR_W];
                    end
                    if (ramstate == RamAccess) begin
                        state_d = StIdle;
                        if (cls_q) begin
                            dwait[gidx_q] = 1'b0;
                            dptr_d        = gidx_nxt;
                            if (|iREN) begin
                                run_d = (run_q == RW'(MAX_DATA_RUN)) ? run_q : run_q + 1'b1;
                            end else begin
                                run_d = '0;
                            end
                        end else begin
                            iwait[gidx_q] = 1'b0;
                            iptr_d        = gidx_nxt;
                            run_d         = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cls_q   <= 1'b0;
            gidx_q  <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            gidx_q  <= gidx_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
            run_q   <= run_d;
        end
    end

endmodule
